sdram_burst_writer: RTL and testbench
=====================================

Name: sdram_burst_writer

Overview:
- Ping-pong page buffer that sits directly upstream of sdram_controller on the write path.
- Accepts a valid/ready stream of 16-bit words. Collects exactly BURST_LEN words (one full page) into one of two buffers.
- Issues a full-page write request to the controller and feeds the buffered words on f2s_data_valid.
- The second buffer keeps filling while the first is being bursted, so producers see no gaps.

Parameters:
- BURST_LEN, 512, words per full-page burst; power of two, at least 4.
- ADDR_W, 15, width of the page address passed to f_addr.
- DATA_W, 16, word width.

Ports:
- clk  in  1  system clock (controller clock domain).
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer word valid.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  DATA_W  producer word.
- in_addr  in  ADDR_W  page address; sampled only with the first word of a page.
- rw  out  1  to controller; constant 0 (write).
- rw_en  out  1  to controller; one-cycle write request.
- f_addr  out  ADDR_W  to controller; page address of the buffer being bursted.
- f2s_data  out  DATA_W  to controller; word at the current read index.
- f2s_data_valid  in  1  from controller; the word on f2s_data is consumed at this edge.
- ready  in  1  from controller; idle and able to accept a request.
- busy  out  1  either buffer full or burst FSM not IDLE.
- pages_written  out  20  count of completed page bursts; wraps at 2^20.
- proto_err  out  1  sticky flag: f2s_data_valid seen outside a valid burst slot.

Behaviour:
- Reset values:
  - All outputs 0: in_ready=0 during rst, then 1 on the first cycle after.
  - wr_buf=0, rd_buf=0, wr_idx=0, rd_idx=0, full[1:0]=0, FSM=IDLE.
  - Buffer RAM contents are not reset.
  - Reset mid-burst abandons the page; the controller is reset by the same rst.
- Fill side:
  - in_ready = !full[wr_buf], combinational from registers only; no dependence on in_valid.
  - Accept occurs when in_valid && in_ready. The word is written to buf[wr_buf][wr_idx] and wr_idx increments.
  - If wr_idx==0 on accept, page_addr[wr_buf] <= in_addr.
  - On accept with wr_idx==BURST_LEN-1: full[wr_buf]<=1, wr_buf toggles, wr_idx<=0.
  - With both buffers full, in_ready=0 and in_data/in_valid are ignored.
- Burst FSM:
  - IDLE: if full[rd_buf], go to REQ.
  - REQ: rw_en=1 (combinational) only in a cycle where ready==1; in that cycle go to BURST with rd_idx<=0. Stays in REQ while ready==0.
  - BURST, f2s_data_valid=1 and rd_idx<BURST_LEN: rd_idx increments.
  - BURST, f2s_data_valid=0 and rd_idx==BURST_LEN: full[rd_buf]<=0, rd_buf toggles, pages_written increments, go to IDLE.
  - BURST, f2s_data_valid=1 and rd_idx==BURST_LEN: proto_err<=1 and the word is ignored. f2s_data_valid in IDLE or REQ also sets proto_err.
- Output timing:
  - f2s_data = buf[rd_buf][rd_idx] combinationally (async-read RAM) while in BURST and rd_idx<BURST_LEN, else 0.
  - f2s_data must be valid before the edge at which f2s_data_valid is sampled.
  - f_addr = page_addr[rd_buf], stable from REQ through the end of BURST; 0 in IDLE.
- Simultaneous events:
  - Filler setting full[x] and the burster clearing full[y] in the same cycle both apply; x != y by construction.
  - A page completing fill in the same cycle the FSM returns to IDLE is picked up on the next cycle.
- Latency:
  - Last accepted word of a page to rw_en is 2 cycles when ready=1 (full set, IDLE->REQ, rw_en in REQ).
  - Back-to-back pages: IDLE costs 1 cycle between bursts.

Test Plan:
- Single page: after reset, push 512 words with in_data = 100+i and in_addr=100 on word 0, ready=1, and a controller model asserting f2s_data_valid for 512 cycles. Required: exactly one rw_en pulse, f_addr=100, words 100..611 received in order, pages_written=1, proto_err=0.
- Ping-pong backpressure: hold ready=0 and push 1024 words for pages 5 and 6. Required: in_ready drops to 0 after word 1023, and word 1024 stalls. Release ready: pages 5 then 6 are bursted, in_ready reasserts after page 5 is released, pages_written=2.
- Continuous stream: push 4 pages (addresses 0..3) with in_valid always 1. Required: in_ready stays 1 except while both buffers are full. Data equals addr+i for every word; pages_written=4.
- Protocol error: during BURST, assert f2s_data_valid 513 times. Required: proto_err=1 after the 513th, and rd_idx stays at 512.
- Reset mid-burst: assert rst after 200 words of a burst. Required: the next cycle shows rw_en=0, busy=0, pages_written=0, in_ready=0 (1 after rst deasserts). A subsequent page bursts correctly.
- Wrap: preload pages_written to 2^20-1 via a forced run, complete one page. Required: pages_written=0.

Source files
------------

// File: rtl/sdram_burst_writer.sv
// sdram_burst_writer
// ------------------
// Ping-pong page buffer placed directly upstream of sdram_controller on the
// write path. Producer words arrive on a valid/ready stream and are collected
// into one of two page buffers of BURST_LEN words each. Once a buffer holds a
// full page, a one-cycle write request is issued to the controller. The
// buffered words are then presented on f2s_data, one per f2s_data_valid
// strobe. While one buffer is being bursted, the other keeps filling, so the
// producer sees no gaps.
//
// Ports
//   clk             system clock (controller clock domain)
//   rst             synchronous, active-high reset
//   in_valid        producer word valid
//   in_ready        block can accept a word this cycle
//   in_data         producer word
//   in_addr         page address, sampled only with the first word of a page
//   rw              to controller, constant 0 (write)
//   rw_en           to controller, one-cycle write request
//   f_addr          to controller, page address of the buffer being bursted
//   f2s_data        to controller, word at the current read index
//   f2s_data_valid  from controller, word on f2s_data is consumed at this edge
//   ready           from controller, idle and able to accept a request
//   busy            a buffer is full or the burst FSM is not idle
//   pages_written   count of completed page bursts, wraps at 2^20
//   proto_err       sticky, f2s_data_valid seen outside a valid burst slot

module sdram_burst_writer #(
  parameter int BURST_LEN = 512,
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              rw,
  output logic              rw_en,
  output logic [ADDR_W-1:0] f_addr,
  output logic [DATA_W-1:0] f2s_data,
  input  logic              f2s_data_valid,
  input  logic              ready,
  output logic              busy,
  output logic [19:0]       pages_written,
  output logic              proto_err
);

  localparam int IDX_W = $clog2(BURST_LEN);

  // The read index needs one extra bit so that it can sit at BURST_LEN,
  // meaning "every word of the page has been handed over".
  localparam logic [IDX_W:0]   RD_END  = (IDX_W+1)'(BURST_LEN);
  localparam logic [IDX_W-1:0] WR_LAST = IDX_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    BURST
  } state_t;

  state_t            r_state;
  state_t            w_nextState;

  logic              r_wrBuf;
  logic              r_rdBuf;
  logic [IDX_W-1:0]  r_wrIdx;
  logic [IDX_W:0]    r_rdIdx;
  logic [1:0]        r_full;
  logic [19:0]       r_pagesWritten;
  logic              r_protoErr;
  logic [ADDR_W-1:0] r_pageAddr [2];
  logic [DATA_W-1:0] r_mem [2*BURST_LEN];

  logic              w_accept;
  logic              w_pageFilled;
  logic              w_beat;
  logic              w_done;
  logic              w_badValid;
  logic              w_rdInRange;

  // The ready flag looks only at the full flag of the buffer being filled.
  // It never looks at in_valid. It is held low while rst is asserted, so
  // nothing is offered to the producer during reset.
  assign in_ready     = !rst && !r_full[r_wrBuf];
  assign w_accept     = in_valid && in_ready;
  assign w_pageFilled = w_accept && (r_wrIdx == WR_LAST);
  assign w_rdInRange  = (r_rdIdx < RD_END);

  // Buffer storage and page addresses are plain RAM with no reset. The
  // page address is latched together with the first word of each page.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[{r_wrBuf, r_wrIdx}] <= in_data;
      if (r_wrIdx == '0) begin
        r_pageAddr[r_wrBuf] <= in_addr;
      end
    end
  end

  // Fill-side pointer: advance on every accepted word. At the end of a page,
  // wrap the index and switch to the other buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrIdx <= '0;
      r_wrBuf <= 1'b0;
    end else if (w_accept) begin
      if (w_pageFilled) begin
        r_wrIdx <= '0;
        r_wrBuf <= ~r_wrBuf;
      end else begin
        r_wrIdx <= r_wrIdx + 1'b1;
      end
    end
  end

  // Full flags are shared by the filler (sets) and the burster (clears).
  // The two always address different buffers, so both updates may land in
  // the same cycle without conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= '0;
    end else begin
      if (w_pageFilled) begin
        r_full[r_wrBuf] <= 1'b1;
      end
      if (w_done) begin
        r_full[r_rdBuf] <= 1'b0;
      end
    end
  end

  // Burst FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Burst FSM next-state and strobes.
  // - The request is raised only in a cycle where the controller reports
  //   ready, so rw_en is a single-cycle pulse.
  // - Once every word has been handed over, the burst closes on the first
  //   cycle with no f2s_data_valid.
  // - A strobe that arrives after the last word, or outside BURST, is
  //   flagged as a protocol error and otherwise ignored.
  always_comb begin
    w_nextState = r_state;
    rw_en       = 1'b0;
    w_beat      = 1'b0;
    w_done      = 1'b0;
    w_badValid  = 1'b0;
    case (r_state)
      IDLE: begin
        w_badValid = f2s_data_valid;
        if (r_full[r_rdBuf]) begin
          w_nextState = REQ;
        end
      end
      REQ: begin
        w_badValid = f2s_data_valid;
        if (ready) begin
          rw_en       = 1'b1;
          w_nextState = BURST;
        end
      end
      BURST: begin
        if (w_rdInRange) begin
          w_beat = f2s_data_valid;
        end else if (f2s_data_valid) begin
          w_badValid = 1'b1;
        end else begin
          w_done      = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Read-side bookkeeping: read index, read buffer select, the completed-page
  // counter (wraps naturally at 2^20) and the sticky protocol error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdIdx        <= '0;
      r_rdBuf        <= 1'b0;
      r_pagesWritten <= '0;
      r_protoErr     <= 1'b0;
    end else begin
      if (rw_en) begin
        r_rdIdx <= '0;
      end else if (w_beat) begin
        r_rdIdx <= r_rdIdx + 1'b1;
      end
      if (w_done) begin
        r_rdBuf        <= ~r_rdBuf;
        r_pagesWritten <= r_pagesWritten + 20'd1;
      end
      if (w_badValid) begin
        r_protoErr <= 1'b1;
      end
    end
  end

  // f2s_data is an asynchronous RAM read. The controller therefore sees the
  // current word before the edge at which it samples f2s_data_valid.
  assign rw            = 1'b0;
  assign f_addr        = (r_state != IDLE) ? r_pageAddr[r_rdBuf] : '0;
  assign f2s_data      = (r_state == BURST && w_rdInRange) ?
                         r_mem[{r_rdBuf, r_rdIdx[IDX_W-1:0]}] : '0;
  assign busy          = (|r_full) || (r_state != IDLE);
  assign pages_written = r_pagesWritten;
  assign proto_err     = r_protoErr;

endmodule

// File: tb/tb_sdram_burst_writer.sv
// tb_sdram_burst_writer
// ---------------------
// Directed bench for sdram_burst_writer.
// - A producer task drives pages whose words are address + index.
// - The expected words and page addresses are queued as they are accepted.
// - A small controller model answers each rw_en with BURST_LEN data strobes
//   and compares every word against the queue.

module tb_sdram_burst_writer;

  localparam int BURST_LEN = 512;
  localparam int ADDR_W    = 15;
  localparam int DATA_W    = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] in_addr;
  logic              rw;
  logic              rw_en;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f2s_data;
  logic              f2s_data_valid = 1'b0;
  logic              ready;
  logic              busy;
  logic [19:0]       pages_written;
  logic              proto_err;

  int assertCount = 0;
  int failCount   = 0;

  logic [DATA_W-1:0] expQ[$];
  logic [ADDR_W-1:0] addrQ[$];

  // Controller-model state. The model owns all of it; the main sequence
  // only requests an extra strobe through wantExtra.
  bit ctlActive    = 1'b0;
  int beatsLeft    = 0;
  int beatIdx      = 0;
  int extraBeats   = 0;
  bit protoPending = 1'b0;
  int rwEnCount    = 0;
  bit wantExtra    = 1'b0;

  sdram_burst_writer #(
    .BURST_LEN(BURST_LEN),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_addr       (in_addr),
    .rw            (rw),
    .rw_en         (rw_en),
    .f_addr        (f_addr),
    .f2s_data      (f2s_data),
    .f2s_data_valid(f2s_data_valid),
    .ready         (ready),
    .busy          (busy),
    .pages_written (pages_written),
    .proto_err     (proto_err)
  );

  always #5 clk = ~clk;

  // One comparison point: counts itself and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Producer: offer nPages pages starting at firstAddr, each word being
  // address + index. Words are offered at the falling edge. in_ready is
  // already settled by then, so a word seen with in_ready=1 will be accepted
  // at the next rising edge. stallCycles counts cycles spent waiting.
  task automatic applyStimulus(input int firstAddr, input int nPages,
                               output int stallCycles);
    int waitCnt;
    stallCycles = 0;
    for (int p = 0; p < nPages; p++) begin
      for (int i = 0; i < BURST_LEN; i++) begin
        waitCnt = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_addr  = ADDR_W'(firstAddr + p);
        in_data  = DATA_W'(firstAddr + p + i);
        while (!in_ready && waitCnt < 4000) begin
          stallCycles++;
          waitCnt++;
          @(negedge clk);
        end
        if (!in_ready) begin
          checkOutput("acceptWait", 32'(in_ready), 32'd1);
        end else begin
          expQ.push_back(in_data);
          if (i == 0) addrQ.push_back(in_addr);
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitPages(input logic [19:0] target, input string tag);
    int n;
    n = 0;
    while (pages_written !== target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(pages_written), 32'(target));
  endtask

  // Controller model: on rw_en, answer with BURST_LEN strobes, then one
  // idle cycle that lets the writer close the page. When an extra strobe
  // has been requested, it is inserted after the last word.
  always @(negedge clk) begin
    if (rst) begin
      ctlActive      = 1'b0;
      beatsLeft      = 0;
      beatIdx        = 0;
      extraBeats     = 0;
      protoPending   = 1'b0;
      f2s_data_valid = 1'b0;
    end else begin
      if (ctlActive) begin
        if (beatsLeft > 0) begin
          if (expQ.size() > 0) checkOutput("f2sData", 32'(f2s_data), 32'(expQ.pop_front()));
          else                 checkOutput("scoreboardDepth", 32'(expQ.size()), 32'd1);
          f2s_data_valid = 1'b1;
          beatsLeft--;
          beatIdx++;
        end else if (extraBeats > 0) begin
          checkOutput("protoErrBefore", 32'(proto_err), 32'd0);
          f2s_data_valid = 1'b1;
          extraBeats--;
          protoPending = 1'b1;
        end else begin
          if (protoPending) begin
            checkOutput("protoErrAfter", 32'(proto_err), 32'd1);
            checkOutput("rdIdxHeld", 32'(dut.r_rdIdx), 32'(BURST_LEN));
            protoPending = 1'b0;
          end
          f2s_data_valid = 1'b0;
          ctlActive      = 1'b0;
        end
      end
      if (rw_en) begin
        rwEnCount++;
        if (addrQ.size() > 0) checkOutput("fAddr", 32'(f_addr), 32'(addrQ.pop_front()));
        else                  checkOutput("addrQueueDepth", 32'(addrQ.size()), 32'd1);
        ctlActive  = 1'b1;
        beatsLeft  = BURST_LEN;
        beatIdx    = 0;
        extraBeats = int'(wantExtra);
      end
    end
  end

  // Watchdog so the run always ends, even if the design locks up.
  initial begin
    #1_000_000;
    failCount++;
    $display("[TB] FAIL watchdog: time limit reached, assertions=%0d", assertCount);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int stalls;
    int n;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_addr  = '0;
    ready    = 1'b1;

    // Reset values.
    repeat (3) @(negedge clk);
    checkOutput("rstInReady", 32'(in_ready), 32'd0);
    checkOutput("rstRwEn", 32'(rw_en), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstPages", 32'(pages_written), 32'd0);
    checkOutput("rstProtoErr", 32'(proto_err), 32'd0);
    checkOutput("rstFAddr", 32'(f_addr), 32'd0);
    checkOutput("rstF2sData", 32'(f2s_data), 32'd0);
    checkOutput("rstRw", 32'(rw), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("inReadyAfterRst", 32'(in_ready), 32'd1);

    // Single page at address 100.
    $display("[TB] single page");
    applyStimulus(100, 1, stalls);
    waitPages(20'd1, "singlePages");
    checkOutput("singleRwEnPulses", 32'(rwEnCount), 32'd1);
    checkOutput("singleProtoErr", 32'(proto_err), 32'd0);
    checkOutput("singleQueueEmpty", 32'(expQ.size()), 32'd0);

    // Ping-pong with backpressure: both pages fill while the controller
    // is held not-ready.
    $display("[TB] ping-pong backpressure");
    @(posedge clk);
    #2 ready = 1'b0;
    applyStimulus(5, 2, stalls);
    checkOutput("ppFillStalls", 32'(stalls), 32'd0);
    checkOutput("ppInReadyDropped", 32'(in_ready), 32'd0);
    checkOutput("ppBusy", 32'(busy), 32'd1);
    checkOutput("ppFAddrHeld", 32'(f_addr), 32'd5);
    checkOutput("ppNoRequest", 32'(rwEnCount), 32'd1);
    in_valid = 1'b1;
    in_addr  = ADDR_W'(7);
    in_data  = DATA_W'(7);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput("ppWordStalled", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #2 ready = 1'b1;
    n = 0;
    while (pages_written !== 20'd2 && n < 3000) begin
      checkOutput("ppInReadyHeldLow", 32'(in_ready), 32'd0);
      @(negedge clk);
      n++;
    end
    checkOutput("ppInReadyReassert", 32'(in_ready), 32'd1);
    waitPages(20'd3, "ppPages");
    checkOutput("ppRwEnPulses", 32'(rwEnCount), 32'd3);

    // Continuous stream of four pages. The only stalls are the three-cycle
    // windows where both buffers are full, before pages 2 and 3.
    $display("[TB] continuous stream");
    applyStimulus(0, 4, stalls);
    checkOutput("streamStallCycles", 32'(stalls), 32'd6);
    waitPages(20'd7, "streamPages");
    checkOutput("streamQueueEmpty", 32'(expQ.size()), 32'd0);

    // Protocol error: one strobe too many during a burst.
    $display("[TB] protocol error");
    wantExtra = 1'b1;
    applyStimulus(30, 1, stalls);
    waitPages(20'd8, "protoPages");
    wantExtra = 1'b0;
    checkOutput("protoErrSticky", 32'(proto_err), 32'd1);

    // Reset in the middle of a burst.
    $display("[TB] reset mid-burst");
    applyStimulus(40, 1, stalls);
    n = 0;
    while (beatIdx < 200 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midBurstReached", 32'(beatIdx >= 200), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midRstRwEn", 32'(rw_en), 32'd0);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstPages", 32'(pages_written), 32'd0);
    checkOutput("midRstInReady", 32'(in_ready), 32'd0);
    checkOutput("midRstProtoErr", 32'(proto_err), 32'd0);
    expQ.delete();
    addrQ.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midRstInReadyRelease", 32'(in_ready), 32'd1);
    applyStimulus(41, 1, stalls);
    waitPages(20'd1, "afterRstPages");
    checkOutput("afterRstQueueEmpty", 32'(expQ.size()), 32'd0);

    // Counter wrap: preload the page counter just below 2^20.
    $display("[TB] counter wrap");
    @(negedge clk);
    force dut.r_pagesWritten = 20'hFFFFF;
    @(negedge clk);
    @(negedge clk);
    release dut.r_pagesWritten;
    @(negedge clk);
    checkOutput("wrapPreload", 32'(pages_written), 32'hFFFFF);
    applyStimulus(50, 1, stalls);
    waitPages(20'd0, "wrapPages");
    checkOutput("wrapQueueEmpty", 32'(expQ.size()), 32'd0);
    checkOutput("wrapProtoErr", 32'(proto_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
